// File: rtl/fp_pkg.sv
// fp_pkg: floating-point formats, rounding modes, exception flags and helpers
// shared by the rounding stage and its increment/overflow datapath.
package fp_pkg;
  typedef enum logic [1:0] {FP32, FP64, FP16} fp_format_e;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} roundmode_e;
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;
  function automatic int exp_bits(fp_format_e f);
    return f == FP64 ? 11 : f == FP16 ? 5 : 8;
  endfunction
  function automatic int mant_bits(fp_format_e f);
    return f == FP64 ? 52 : f == FP16 ? 10 : 23;
  endfunction
  function automatic int fp_width(fp_format_e f);
    return 1 + exp_bits(f) + mant_bits(f);
  endfunction
  function automatic logic [63:0] canon_nan(fp_format_e f);
    return f == FP64 ? 64'h7FF8_0000_0000_0000 : f == FP16 ? 64'h0000_0000_0000_7E00 : 64'h0000_0000_7FC0_0000;
  endfunction
  // l = lsb of the kept mantissa, g = first dropped bit, s = OR of the rest
  function automatic logic round_inc(roundmode_e rm, logic sign, logic l, logic g, logic s);
    return rm == RNE ? g & (s | l) : rm == RDN ? sign & (g | s) : rm == RUP ? !sign & (g | s) : rm == RMM ? g : 1'b0;
  endfunction
endpackage

// File: rtl/fp_rnd_inc.sv
// fp_rnd_inc: applies a precomputed round increment, detects overflow and
// builds the final IEEE-754 result and exception flags.
module fp_rnd_inc
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int EW = exp_bits(FP_FORMAT),
  localparam int MW = mant_bits(FP_FORMAT),
  localparam int FW = 1 + EW + MW
) (
  input  logic [FW-1:0] i_u_result,
  input  logic [1:0]    i_rs,
  input  logic          i_inc,
  input  logic          i_round_en,
  input  logic          i_invalid,
  input  logic [1:0]    i_exp_cout,
  input  roundmode_e    i_rnd,
  output logic [FW-1:0] o_result,
  output logic [4:0]    o_fflags
);
  localparam logic [63:0] NAN64 = canon_nan(FP_FORMAT);
  localparam logic [EW+MW-1:0] INF_MAG = {{EW{1'b1}}, {MW{1'b0}}};
  localparam logic [EW+MW-1:0] MAX_MAG = {{(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
  logic            w_sign;
  logic [EW+MW-1:0] w_mag;
  logic            w_of;
  logic            w_nx;
  logic            w_to_inf;
  fflags_t         w_flags;
  assign w_sign = i_u_result[FW-1];
  // a mantissa carry ripples into the exponent, covering subnormal->normal
  assign w_mag = i_u_result[EW+MW-1:0] + (EW + MW)'(i_inc);
  assign w_of = i_exp_cout == 2'b01 || &w_mag[EW+MW-1:MW];
  assign w_nx = |i_rs | w_of;
  assign w_to_inf = i_rnd == RNE || i_rnd == RMM || (i_rnd == RUP && !w_sign) || (i_rnd == RDN && w_sign);
  always_comb begin
    w_flags = '0;
    o_result = i_u_result;
    if (i_invalid) begin
      o_result = NAN64[FW-1:0];
      w_flags.nv = 1'b1;
    end else if (i_round_en) begin
      o_result = {w_sign, w_of ? (w_to_inf ? INF_MAG : MAX_MAG) : w_mag};
      w_flags.of = w_of;
      w_flags.nx = w_nx;
      w_flags.uf = w_nx & ~|i_u_result[EW+MW-1:MW];
    end
  end
  assign o_fflags = w_flags;
endmodule

// File: rtl/fp_rnd_stage.sv
// fp_rnd_stage: two-stage valid/ready rounding pipeline; S1 captures the
// increment decision, S2 holds the rounded result and flags.
module fp_rnd_stage
  import fp_pkg::*;
#(
  parameter fp_format_e FP_FORMAT = FP32,
  localparam int FP_WIDTH = fp_width(FP_FORMAT),
  localparam int EXP_WIDTH = exp_bits(FP_FORMAT),
  localparam int MANT_WIDTH = mant_bits(FP_FORMAT)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [FP_WIDTH+5:0] urnd_i,
  input  roundmode_e          rnd_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                flush_i,
  output logic [FP_WIDTH-1:0] result_o,
  output logic [4:0]          fflags_o,
  output logic                valid_o,
  input  logic                ready_i
);
  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0] mant;
    logic [1:0]            rs;
    logic                  round_en;
    logic                  invalid;
    logic [1:0]            exp_cout;
  } uround_res_t;
  uround_res_t         w_urnd;
  logic                w_inc;
  logic                w_s2_en;
  logic [FP_WIDTH-1:0] w_res;
  logic [4:0]          w_flags;
  logic                r_s1_v;
  uround_res_t         r_s1;
  logic                r_s1_inc;
  roundmode_e          r_s1_rnd;
  logic                r_s2_v;
  logic [FP_WIDTH-1:0] r_s2_res;
  logic [4:0]          r_s2_flags;
  assign w_urnd = urnd_i;
  assign w_inc = round_inc(rnd_i, w_urnd.sign, w_urnd.mant[0], w_urnd.rs[1], w_urnd.rs[0]);
  assign w_s2_en = !r_s2_v | ready_i;
  assign ready_o = !r_s1_v | w_s2_en;
  fp_rnd_inc #(.FP_FORMAT(FP_FORMAT)) u_inc (
    .i_u_result({r_s1.sign, r_s1.exp, r_s1.mant}),
    .i_rs      (r_s1.rs),
    .i_inc     (r_s1_inc),
    .i_round_en(r_s1.round_en),
    .i_invalid (r_s1.invalid),
    .i_exp_cout(r_s1.exp_cout),
    .i_rnd     (r_s1_rnd),
    .o_result  (w_res),
    .o_fflags  (w_flags)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_v <= 1'b0;
      r_s1 <= '0;
      r_s1_inc <= 1'b0;
      r_s1_rnd <= RNE;
      r_s2_v <= 1'b0;
      r_s2_res <= '0;
      r_s2_flags <= '0;
    end else begin
      if (ready_o) begin
        r_s1_v <= valid_i & !flush_i;
        r_s1 <= w_urnd;
        r_s1_inc <= w_inc;
        r_s1_rnd <= rnd_i;
      end
      if (w_s2_en) begin
        r_s2_v <= r_s1_v & !flush_i;
        r_s2_res <= w_res;
        r_s2_flags <= w_flags;
      end
      if (flush_i) begin
        r_s1_v <= 1'b0;
        r_s2_v <= 1'b0;
      end
    end
  end
  assign valid_o = r_s2_v;
  assign result_o = r_s2_res;
  assign fflags_o = r_s2_flags;
endmodule

// File: tb/tb_fp_rnd_stage.sv
// tb_fp_rnd_stage: scoreboard bench for the FP32 rounding stage; expected
// results come from a value-level rounding model, checked by a separate monitor.
module tb_fp_rnd_stage;
  import fp_pkg::*;
  typedef struct {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
    logic [1:0] rs;
    logic       round_en;
    logic       invalid;
    logic [1:0] exp_cout;
    roundmode_e rm;
  } item_t;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    bit          lat;
    time         t;
  } exp_t;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [37:0] urnd_i = '0;
  roundmode_e  rnd_i = RNE;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        flush_i = 1'b0;
  logic [31:0] result_o;
  logic [4:0]  fflags_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  int          checks = 0;
  int          fails = 0;
  exp_t        sb[$];
  bit          hold_pend = 0;
  bit          prev_fl = 0;
  logic [31:0] h_res;
  logic [4:0]  h_fl;

  fp_rnd_stage #(.FP_FORMAT(FP32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .urnd_i(urnd_i), .rnd_i(rnd_i), .valid_i(valid_i),
    .ready_o(ready_o), .flush_i(flush_i), .result_o(result_o), .fflags_o(fflags_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  initial forever #5 clk_i = ~clk_i;

  // Value-level rounding: compare the dropped fraction against one half.
  function automatic exp_t model(item_t it);
    exp_t e;
    bit g, s, above, tie, up, of, to_inf;
    int unsigned mag;
    e.res = {it.sign, it.exp, it.mant};
    e.fl = 5'b0;
    e.lat = 0;
    e.t = 0;
    if (it.invalid) begin
      e.res = 32'h7FC00000;
      e.fl = 5'b10000;
      return e;
    end
    if (!it.round_en) return e;
    g = it.rs[1];
    s = it.rs[0];
    above = g && s;
    tie = g && !s;
    case (it.rm)
      RNE: up = above || (tie && it.mant[0]);
      RTZ: up = 0;
      RDN: up = it.sign && (g || s);
      RUP: up = !it.sign && (g || s);
      default: up = above || tie;
    endcase
    mag = 32'({it.exp, it.mant}) + 32'(up);
    of = it.exp_cout == 2'b01 || mag >= 32'h7F800000;
    to_inf = it.rm == RNE || it.rm == RMM || (it.rm == RUP && !it.sign) || (it.rm == RDN && it.sign);
    e.res = of ? {it.sign, to_inf ? 31'h7F800000 : 31'h7F7FFFFF} : {it.sign, mag[30:0]};
    e.fl[2] = of;
    e.fl[0] = g || s || of;
    e.fl[1] = e.fl[0] && it.exp == 8'd0;
    return e;
  endfunction

  function automatic item_t mk(logic sg, logic [7:0] ex, logic [22:0] ma, logic [1:0] rs,
                               roundmode_e rm, logic re, logic inv, logic [1:0] ec);
    item_t it;
    it.sign = sg; it.exp = ex; it.mant = ma; it.rs = rs; it.rm = rm;
    it.round_en = re; it.invalid = inv; it.exp_cout = ec;
    return it;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step(input logic v, input item_t it, input logic rdy, input logic fl,
                      input bit lat, output bit acc);
    exp_t e;
    time tn;
    valid_i = v;
    urnd_i = {it.sign, it.exp, it.mant, it.rs, it.round_en, it.invalid, it.exp_cout};
    rnd_i = it.rm;
    ready_i = rdy;
    flush_i = fl;
    @(negedge clk_i);
    acc = v && ready_o && !fl;
    tn = $time;
    @(posedge clk_i);
    if (fl) sb.delete();
    if (acc) begin
      e = model(it);
      e.lat = lat;
      e.t = tn;
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic send(input item_t it, input bit lat);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 50) begin
      step(1'b1, it, 1'b1, 1'b0, lat, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      fails++;
      $display("FAIL send_timeout got=not_accepted want=accepted");
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    item_t z = mk(0, 0, 0, 0, RNE, 0, 0, 0);
    repeat (n) step(1'b0, z, 1'b1, 1'b0, 0, acc);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) hold_pend = 0;
    else begin
      if (hold_pend && !prev_fl) begin
        checks++;
        if (valid_o !== 1'b1 || result_o !== h_res || fflags_o !== h_fl) begin
          fails++;
          $display("FAIL hold got=%b/%h/%b want=1/%h/%b", valid_o, result_o, fflags_o, h_res, h_fl);
        end
      end
      hold_pend = valid_o && !ready_i;
      h_res = result_o;
      h_fl = fflags_o;
      if (valid_o && ready_i) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output got=%h want=none", result_o);
        end else begin
          e = sb.pop_front();
          if (result_o !== e.res || fflags_o !== e.fl) begin
            fails++;
            $display("FAIL result got=%h/%b want=%h/%b", result_o, fflags_o, e.res, e.fl);
          end
          if (e.lat) begin
            checks++;
            if ($time - e.t != 20) begin
              fails++;
              $display("FAIL latency got=%0t want=20", $time - e.t);
            end
          end
        end
      end
    end
    prev_fl = flush_i;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    item_t a, b, c;
    #1;
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_result", result_o, 32'd0);
    chk("reset_fflags", 32'(fflags_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("ready_after_reset", 32'(ready_o), 32'd1);
    send(mk(0, 8'h7F, 23'h000001, 2'b10, RNE, 1, 0, 0), 1);
    idle(3);
    send(mk(0, 8'hFE, 23'h7FFFFF, 2'b11, RNE, 1, 0, 2'b00), 1);
    idle(3);
    send(mk(0, 8'hFE, 23'h7FFFFF, 2'b11, RTZ, 1, 0, 2'b01), 1);
    idle(3);
    send(mk(1, 8'hFE, 23'h7FFFFF, 2'b11, RUP, 1, 0, 2'b00), 1);
    send(mk(0, 8'h00, 23'h7FFFFF, 2'b10, RNE, 1, 0, 0), 1);
    idle(3);
    send(mk(1, 8'h55, 23'h123456, 2'b01, RDN, 1, 1, 0), 0);
    send(mk(0, 8'h81, 23'h2AAAAA, 2'b11, RMM, 0, 0, 2'b01), 0);
    idle(4);
    a = mk(0, 8'h10, 23'h000010, 2'b10, RNE, 1, 0, 0);
    b = mk(1, 8'h20, 23'h000011, 2'b10, RMM, 1, 0, 0);
    c = mk(0, 8'h30, 23'h7FFFFF, 2'b01, RUP, 1, 0, 0);
    step(1, a, 0, 0, 0, acc);
    chk("bp_accept_a", 32'(acc), 32'd1);
    step(1, b, 0, 0, 0, acc);
    chk("bp_accept_b", 32'(acc), 32'd1);
    step(1, c, 0, 0, 0, acc);
    chk("bp_ready_full", 32'(acc), 32'd0);
    send(c, 0);
    idle(4);
    chk("bp_drained", 32'(sb.size()), 32'd0);
    step(1, a, 0, 0, 0, acc);
    step(1, b, 0, 0, 0, acc);
    step(1, c, 0, 1, 0, acc);
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_ready", 32'(ready_o), 32'd1);
    idle(4);
    step(1, a, 0, 0, 0, acc);
    step(1, b, 0, 0, 0, acc);
    #2 rst_i = 1'b1;
    #1;
    chk("async_reset_valid", 32'(valid_o), 32'd0);
    chk("async_reset_result", result_o, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    send(mk(1, 8'h00, 23'h000001, 2'b11, RDN, 1, 0, 0), 1);
    idle(4);
    for (int i = 0; i < 500; i++) begin
      item_t it;
      logic [2:0] ek = 3'($urandom_range(0, 4));
      logic [1:0] mk_sel = 2'($urandom_range(0, 3));
      it.sign = 1'($urandom);
      it.exp = ek == 0 ? 8'h00 : ek == 1 ? 8'hFE : ek == 2 ? 8'h7F : 8'($urandom_range(0, 254));
      it.mant = mk_sel == 0 ? 23'h7FFFFF : mk_sel == 1 ? 23'h0 : 23'($urandom);
      it.rs = 2'($urandom);
      it.rm = roundmode_e'(3'($urandom_range(0, 4)));
      it.round_en = $urandom_range(0, 7) != 0;
      it.invalid = $urandom_range(0, 15) == 0;
      it.exp_cout = $urandom_range(0, 7) == 0 ? 2'b01 : 2'($urandom_range(0, 3)) & 2'b10;
      step(1'($urandom_range(0, 4) != 0), it, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 99) == 0), 0, acc);
    end
    idle(6);
    chk("final_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
